// File: rtl/keyboard_host_tx_pkg.sv
// keyboard_host_tx_pkg
//   Shared definitions for the PS/2 host-to-device transmitter:
//   FSM state encoding, frame length and default timing constants.
//   Holds no ports; imported by keyboard_host_tx.

package keyboard_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  // Device clock falling edges per transmitted frame: 8 data, parity,
  // stop, acknowledge. The start bit is presented before the first edge.
  localparam int FRAME_EDGES = 11;

  // 100 us inhibit and 20 ms watchdog at a 50 MHz system clock.
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  // One counter serves both the inhibit interval and the watchdog,
  // so it is sized for the larger of the two.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/keyboard_negedge_detector.sv
// keyboard_negedge_detector
//   Falling-edge detector for the raw PS/2 clock pad. The pad is brought
//   in through a 2-flop synchronizer and then sampled once every 32 clk
//   cycles, which filters short glitches on the slow PS/2 clock. A
//   one-cycle pulse is produced when a sample is low and the previous
//   sample was high. Worst-case lag from the pad edge is about 35 clk.
//
//   Ports:
//     clk        in  system clock
//     rst        in  synchronous active-high reset
//     i_ps2_clk  in  raw PS/2 clock line
//     o_edge_en  out one-cycle pulse per detected falling edge

module keyboard_negedge_detector (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  output logic o_edge_en
);

  logic [1:0] sync;
  logic [4:0] div;
  logic       prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      div       <= 5'd0;
      prev      <= 1'b1;
      o_edge_en <= 1'b0;
    end else begin
      sync      <= {sync[0], i_ps2_clk};
      div       <= div + 5'd1;
      o_edge_en <= 1'b0;
      if (div == 5'd31) begin
        prev      <= sync[1];
        o_edge_en <= prev & ~sync[1];
      end
    end
  end

endmodule

// File: rtl/keyboard_host_tx.sv
// keyboard_host_tx
//   PS/2 host-to-device transmitter. Accepts one command byte and sends it
//   using the request-to-send sequence: inhibit (clock held low), start bit
//   with clock released, then 8 data bits LSB first, odd parity and stop,
//   each placed on the line after a device clock falling edge, followed by
//   the device acknowledge. Lines are open-drain; an OE of 1 pulls low.
//
//   Optional build macro: KEYBOARD_TX_TIMEOUT_EN adds a watchdog that
//   abandons the frame when the device stops clocking.
//
//   Ports:
//     clk           in  system clock
//     i_sclr_n      in  synchronous active-low reset
//     i_valid       in  byte request
//     i_data[7:0]   in  byte to send
//     o_ready       out idle, a byte can be accepted
//     i_ps2_clk     in  raw PS/2 clock pad
//     i_ps2_dat     in  raw PS/2 data pad
//     o_ps2_clk_oe  out 1 = pull clock line low
//     o_ps2_dat_oe  out 1 = pull data line low
//     o_done        out one-cycle pulse when the frame is acknowledged
//     o_err         out one-cycle pulse on NACK (or watchdog timeout)
//
//   Handshake: a byte transfers in any cycle where i_valid and o_ready are
//   both 1; i_valid while o_ready is 0 is ignored, nothing is queued.

module keyboard_host_tx
  import keyboard_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       i_sclr_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe,
  output logic       o_done,
  output logic       o_err
);

  localparam int CW = cnt_width(INHIBIT_CYCLES, TIMEOUT_CYCLES);

  state_t        state, state_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic [3:0]    bit_cnt, bit_cnt_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          drive_low, drive_low_d;
  logic          acked, acked_d;
  logic [1:0]    dat_sync, clk_sync;
  logic          edge_en;
  logic          done, err;

  keyboard_negedge_detector u_edge (
    .clk       (clk),
    .rst       (~i_sclr_n),
    .i_ps2_clk (i_ps2_clk),
    .o_edge_en (edge_en)
  );

  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      state     <= IDLE;
      data_q    <= 8'h00;
      parity_q  <= 1'b0;
      bit_cnt   <= 4'd0;
      cnt       <= '0;
      drive_low <= 1'b0;
      acked     <= 1'b0;
      dat_sync  <= 2'b11;
      clk_sync  <= 2'b11;
    end else begin
      state     <= state_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      bit_cnt   <= bit_cnt_d;
      cnt       <= cnt_d;
      drive_low <= drive_low_d;
      acked     <= acked_d;
      dat_sync  <= {dat_sync[0], i_ps2_dat};
      clk_sync  <= {clk_sync[0], i_ps2_clk};
    end
  end

  always_comb begin
    state_d     = state;
    data_d      = data_q;
    parity_d    = parity_q;
    bit_cnt_d   = bit_cnt;
    cnt_d       = cnt;
    drive_low_d = drive_low;
    acked_d     = acked;
    done        = 1'b0;
    err         = 1'b0;

    case (state)
      IDLE: begin
        if (i_valid) begin
          data_d    = i_data;
          parity_d  = ~^i_data;
          bit_cnt_d = 4'd0;
          cnt_d     = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = RTS;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RTS: begin
        // Start bit keeps data low once the clock is released.
        drive_low_d = 1'b1;
        bit_cnt_d   = 4'd0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (edge_en) begin
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            drive_low_d = ~data_q[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            drive_low_d = ~parity_q;
          end else begin
            // Stop bit: release data; next edge is the acknowledge.
            drive_low_d = 1'b0;
            state_d     = ACK;
          end
        end
      end
      ACK: begin
        if (edge_en) begin
          acked_d = ~dat_sync[1];
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync[1] && dat_sync[1]) begin
          done    = acked;
          err     = ~acked;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef KEYBOARD_TX_TIMEOUT_EN
    // Watchdog: any device clock activity restarts the count.
    if (state inside {RTS, SHIFT, ACK, WAIT_IDLE}) begin
      if (edge_en) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt + CW'(1);
      end
      if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        done    = 1'b0;
        err     = 1'b1;
        state_d = IDLE;
      end
    end
`endif
  end

  // OEs are decoded from registered state only, so they change cleanly
  // one cycle after the deciding event.
  assign o_ready      = (state == IDLE);
  assign o_ps2_clk_oe = (state == INHIBIT) || (state == RTS);
  assign o_ps2_dat_oe = (state == RTS) || ((state == SHIFT) && drive_low);
  // A reset cycle never reports a completed or failed frame.
  assign o_done       = done & i_sclr_n;
  assign o_err        = err & i_sclr_n;

endmodule

// File: tb/tb_keyboard_host_tx.sv
// tb_keyboard_host_tx
//   Directed bench for keyboard_host_tx with a behavioural PS/2 device.
//   Device half-period is 100 clk, far above the detector lag.

module tb_keyboard_host_tx;

  localparam int HALF = 100;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       i_sclr_n;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_ps2_clk_oe;
  logic       o_ps2_dat_oe;
  logic       o_done;
  logic       o_err;
  logic       dev_clk_low;
  logic       dev_dat_low;
  logic       ps2_clk_line;
  logic       ps2_dat_line;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Open-drain bus with pull-ups.
  assign ps2_clk_line = ~(o_ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(o_ps2_dat_oe | dev_dat_low);

  keyboard_host_tx #(
    .INHIBIT_CYCLES (64),
    .TIMEOUT_CYCLES (20000)
  ) dut (
    .clk          (clk),
    .i_sclr_n     (i_sclr_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .i_ps2_clk    (ps2_clk_line),
    .i_ps2_dat    (ps2_dat_line),
    .o_ps2_clk_oe (o_ps2_clk_oe),
    .o_ps2_dat_oe (o_ps2_dat_oe),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic pend_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pend_ready) check("ready_after_pulse", o_ready, 1);
    pend_ready <= 1'b0;
    if (i_sclr_n && (o_done || o_err)) begin
      check("done_err_excl", o_done & o_err, 0);
      done_cnt   <= done_cnt + int'(o_done);
      err_cnt    <= err_cnt + int'(o_err);
      pend_ready <= 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  // Accepts a byte and checks inhibit length, RTS cycle and clock release.
  task automatic host_send(input logic [7:0] d);
    int n;
    @(negedge clk);
    check("ready_before", o_ready, 1);
    i_valid = 1'b1;
    i_data  = d;
    @(negedge clk);
    i_valid = 1'b0;
    check("ready_after_accept", o_ready, 0);
    n = 0;
    while (o_ps2_clk_oe && !o_ps2_dat_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, 64);
    check("rts_oe", {o_ps2_clk_oe, o_ps2_dat_oe}, 2'b11);
    @(negedge clk);
    check("shift_oe", {o_ps2_clk_oe, o_ps2_dat_oe}, 2'b01);
  endtask

  // Device: waits for RTS, captures start then one bit per rising edge,
  // and on the 11th clock pulls data low unless told to NACK.
  task automatic device_frame(input int n_fall, input bit nack,
                              output logic [10:0] bits, output bit ok);
    int guard;
    bits  = '0;
    ok    = 1'b0;
    guard = 0;
    while (!(ps2_dat_line == 1'b0 && ps2_clk_line == 1'b1) && guard < 5000) begin
      guard++;
      @(negedge clk);
    end
    if (guard < 5000) begin
      ok = 1'b1;
      repeat (HALF) @(negedge clk);
      bits[0] = ps2_dat_line;
      for (int i = 1; i <= 10 && i <= n_fall; i++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        bits[i] = ps2_dat_line;
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
      if (n_fall >= 11) begin
        if (!nack) dev_dat_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        dev_dat_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  // Full frame; par is the hand-computed odd parity bit.
  task automatic run_frame(input logic [7:0] d, input logic par, input bit nack, input bit inject);
    logic [10:0] bits;
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      host_send(d);
      device_frame(11, nack, bits, ok);
      begin
        if (inject) begin
          repeat (400) @(negedge clk);
          i_valid = 1'b1;
          i_data  = 8'h55;
          @(negedge clk);
          check("ready_in_shift", o_ready, 0);
          i_valid = 1'b0;
        end
      end
    join
    repeat (50) @(negedge clk);
    check("dev_saw_rts", ok, 1);
    check("frame_bits", bits, {1'b1, par, d, 1'b0});
    check("done_pulses", done_cnt - d0, nack ? 0 : 1);
    check("err_pulses", err_cnt - e0, nack ? 1 : 0);
    check("ready_idle", o_ready, 1);
    check("oe_idle", {o_ps2_clk_oe, o_ps2_dat_oe}, 2'b00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [10:0] bits;
    bit ok;
    int n, d0, e0;
    i_sclr_n    = 1'b0;
    i_valid     = 1'b0;
    i_data      = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_ready", o_ready, 1);
    check("rst_oe", {o_ps2_clk_oe, o_ps2_dat_oe}, 2'b00);
    check("rst_pulses", {o_done, o_err}, 2'b00);
    i_sclr_n = 1'b1;
    repeat (40) @(negedge clk);

    run_frame(8'hED, 1'b1, 1'b0, 1'b0);
    run_frame(8'h01, 1'b0, 1'b0, 1'b0);
    run_frame(8'h00, 1'b1, 1'b0, 1'b0);
    run_frame(8'hAB, 1'b0, 1'b1, 1'b0);  // NACK
    run_frame(8'h3C, 1'b1, 1'b0, 1'b1);  // 0x55 offered mid-frame

    // Device never clocks.
    e0 = err_cnt;
    host_send(8'hFF);
`ifdef KEYBOARD_TX_TIMEOUT_EN
    n = 1;
    while (!o_err && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, 19999);
    @(negedge clk);
    check("timeout_oe", {o_ps2_clk_oe, o_ps2_dat_oe}, 2'b00);
    check("timeout_ready", o_ready, 1);
`else
    repeat (25000) @(negedge clk);
    check("stall_oe", {o_ps2_clk_oe, o_ps2_dat_oe}, 2'b01);
    check("stall_ready", o_ready, 0);
    check("stall_no_err", err_cnt - e0, 0);
    i_sclr_n = 1'b0;
    @(negedge clk);
    check("stall_rst_oe", {o_ps2_clk_oe, o_ps2_dat_oe}, 2'b00);
    i_sclr_n = 1'b1;
    repeat (40) @(negedge clk);
`endif

    // Reset after the 4th device edge.
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      host_send(8'h12);
      device_frame(4, 1'b0, bits, ok);
    join
    check("partial_bits", bits[4:0], 5'b00100);
    @(negedge clk);
    i_sclr_n = 1'b0;
    @(negedge clk);
    check("midrst_oe", {o_ps2_clk_oe, o_ps2_dat_oe}, 2'b00);
    check("midrst_ready", o_ready, 1);
    i_sclr_n = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    run_frame(8'hF4, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
